lsu_mem_stage: RTL and testbench

Parametrised load/store memory stage for the RISC-V core, placed between execute and writeback. Accepts one load or store per handshake from execute, decodes the address to byte-laned data memory or an N-channel MMIO window, and performs sized, sign- or zero-extended accesses. Returns the result to writeback through a valid/ready handshake, with a small FSM covering the synchronous-read memory latency.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_mem_stage_if.sv | 46 ++++
 rtl/dmem_lane.sv | 29 ++
 rtl/lsu_mem_stage.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants, FSM state type and byte-lane helper for the
//               load/store memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0]  c_f3_byte   = 3'b000;
    localparam logic [2:0]  c_f3_half   = 3'b001;
    localparam logic [2:0]  c_f3_word   = 3'b010;
    localparam logic [2:0]  c_f3_byte_u = 3'b100;
    localparam logic [2:0]  c_f3_half_u = 3'b101;

    localparam logic [31:0] c_mmio_base_default = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Halfword at offset 3 would straddle words, so it selects no lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = (off == 2'd3) ? 4'b0000 : (4'b0011 << off);
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_if
// Description : Execute-side request and writeback-side result handshakes of
//               the memory stage. mem_misalign exists only with
//               MISALIGN_TRAP_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_value;
    logic [4:0]  ex_dstreg_num;
    logic        ex_reg_we;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dstreg_num;
    logic        mem_reg_we;
    logic [31:0] mem_load_value;
`ifdef MISALIGN_TRAP_EN
    logic        mem_misalign;
`endif

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr,
               ex_store_value, ex_dstreg_num, ex_reg_we, mem_ready,
        input  ex_ready, mem_valid, mem_dstreg_num, mem_reg_we, mem_load_value
`ifdef MISALIGN_TRAP_EN
        , input mem_misalign
`endif
    );

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr,
               ex_store_value, ex_dstreg_num, ex_reg_we, mem_ready,
        output ex_ready, mem_valid, mem_dstreg_num, mem_reg_we, mem_load_value
`ifdef MISALIGN_TRAP_EN
        , output mem_misalign
`endif
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane
// Description : One 8-bit byte lane of data memory, synchronous read with
//               read enable, write enable. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic          i_re,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [7:0]    i_wdata,
    output logic      [7:0]    o_rdata
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : Load/store memory stage: byte-laned DMEM plus N-channel MMIO
//               window, IDLE/BUSY/DONE handshake FSM. Optional misaligned
//               access trapping with MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int          DMEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE  = c_mmio_base_default,
    parameter int          N_MMIO     = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    lsu_mem_stage_if.slave             lsu,
    input  wire logic [32*N_MMIO-1:0]  mmio_rd_data,
    output logic      [N_MMIO-1:0]     mmio_wr_en,
    output logic      [31:0]           mmio_wr_data
);
    localparam int          c_aw         = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [32:0] c_dmem_bytes = 33'(DMEM_WORDS) * 33'd4;

    lsu_state_t   r_state;
    logic [31:0]  r_addr;
    logic [2:0]   r_funct3;
    logic         r_is_load;
    logic         r_is_store;
    logic [31:0]  r_store_value;
    logic [4:0]   r_dstreg;
    logic         r_reg_we;
    logic [31:0]  r_mmio_hold;

    logic              w_accept;
    logic              w_busy;
    logic              w_dmem_hit;
    logic              w_mmio_hit;
    logic [N_MMIO-1:0] w_mmio_sel;
    logic [31:0]       w_mmio_rdata;
    logic              w_misalign;
    logic [3:0]        w_lane_we;
    logic              w_dmem_re;
    logic [31:0]       w_wdata;
    logic [3:0][7:0]   w_rd;
    logic [31:0]       w_ram_word;
    logic [1:0]        w_half_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_fmt;
    logic [31:0]       w_load_value;

    assign lsu.ex_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && lsu.mem_ready);
    assign w_accept     = lsu.ex_valid && lsu.ex_ready;
    assign w_busy       = (r_state == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_funct3      <= '0;
            r_is_load     <= 1'b0;
            r_is_store    <= 1'b0;
            r_store_value <= '0;
            r_dstreg      <= '0;
            r_reg_we      <= 1'b0;
            r_mmio_hold   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= ST_BUSY;
                ST_BUSY: r_state <= ST_DONE;
                ST_DONE: if (lsu.mem_ready) r_state <= w_accept ? ST_BUSY : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_addr        <= lsu.ex_addr;
                r_funct3      <= lsu.ex_funct3;
                r_is_load     <= lsu.ex_is_load;
                r_is_store    <= lsu.ex_is_store;
                r_store_value <= lsu.ex_store_value;
                r_dstreg      <= lsu.ex_dstreg_num;
                r_reg_we      <= lsu.ex_reg_we;
            end
            if (w_busy && r_is_load && w_mmio_hit) r_mmio_hold <= w_mmio_rdata;
        end
    end

    assign w_dmem_hit = ({1'b0, r_addr} < c_dmem_bytes);

    // MMIO base is word aligned, so a word-address match equals the range test.
    for (genvar k = 0; k < N_MMIO; k++) begin : g_mmio_sel
        assign w_mmio_sel[k] = (r_addr[31:2] == (MMIO_BASE[31:2] + 30'(k)));
        assign mmio_wr_en[k] = w_busy && r_is_store && w_mmio_sel[k] && !w_misalign;
    end
    assign w_mmio_hit   = |w_mmio_sel;
    assign mmio_wr_data = r_store_value;

    always_comb begin
        w_mmio_rdata = '0;
        for (int k = 0; k < N_MMIO; k++) begin
            if (w_mmio_sel[k]) w_mmio_rdata = mmio_rd_data[32*k +: 32];
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (r_funct3[1] && (r_addr[1:0] != 2'd0))
                     || ((r_funct3[1:0] == 2'b01) && (r_addr[1:0] == 2'd3))
                     || (w_mmio_hit && !r_funct3[1]);
`else
    assign w_misalign = 1'b0;
`endif

    // Write enables follow the state directly so an async reset kills them at once.
    assign w_lane_we = (w_busy && r_is_store && w_dmem_hit && !w_misalign)
                     ? lane_mask(r_funct3, r_addr[1:0]) : 4'b0000;
    assign w_dmem_re = w_busy && r_is_load && w_dmem_hit;
    assign w_wdata   = r_funct3[1] ? r_store_value
                                   : (r_store_value << {r_addr[1:0], 3'b000});

    for (genvar l = 0; l < 4; l++) begin : g_lane
        dmem_lane #(
            .DEPTH (DMEM_WORDS),
            .AW    (c_aw)
        ) u_lane (
            .clk     (clk),
            .i_we    (w_lane_we[l]),
            .i_re    (w_dmem_re),
            .i_addr  (r_addr[c_aw+1:2]),
            .i_wdata (w_wdata[8*l +: 8]),
            .o_rdata (w_rd[l])
        );
    end

    assign w_ram_word = w_rd;
    assign w_half_off = (r_addr[1:0] == 2'd3) ? 2'd0 : r_addr[1:0];
    assign w_byte     = w_ram_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = w_ram_word[{w_half_off, 3'b000} +: 16];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_fmt = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_fmt = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_fmt = w_ram_word;
        endcase
        w_load_value = '0;
        if ((r_state == ST_DONE) && r_is_load && !w_misalign) begin
            if (w_dmem_hit)      w_load_value = w_fmt;
            else if (w_mmio_hit) w_load_value = r_mmio_hold;
        end
    end

    assign lsu.mem_valid      = (r_state == ST_DONE);
    assign lsu.mem_load_value = w_load_value;
    assign lsu.mem_dstreg_num = r_dstreg;
    assign lsu.mem_reg_we     = r_reg_we && !w_misalign;
`ifdef MISALIGN_TRAP_EN
    assign lsu.mem_misalign   = (r_state == ST_DONE) && w_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_stage
// Description : Self-checking bench for lsu_mem_stage against a byte-level
//               memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;
    localparam int          DMEM_WORDS = 4096;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;
    localparam int          N_MMIO     = 4;
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

    logic         clk;
    logic         rst_n;
    logic [127:0] mmio_rd_data;
    logic [3:0]   mmio_wr_en;
    logic [31:0]  mmio_wr_data;

    lsu_mem_stage_if ifc ();

    lsu_mem_stage #(
        .DMEM_WORDS (DMEM_WORDS),
        .MMIO_BASE  (MMIO_BASE),
        .N_MMIO     (N_MMIO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu          (ifc),
        .mmio_rd_data (mmio_rd_data),
        .mmio_wr_en   (mmio_wr_en),
        .mmio_wr_data (mmio_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [int unsigned];

    int          wr_cycles;
    logic [3:0]  wr_en_seen;
    logic [31:0] wr_data_seen;

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= MMIO_BASE) && (a < MMIO_BASE + 32'(4 * N_MMIO));
    endfunction

    function automatic bit model_misalign(input logic [31:0] a, input logic [2:0] f3);
`ifdef MISALIGN_TRAP_EN
        if (is_mmio(a) && f3 != 3'b010) return 1'b1;
        if (f3 == 3'b010) return (a % 4) != 0;
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 4) == 3;
        return 1'b0;
`else
        return (a == 32'hFFFF_FFFF) && (f3 == 3'b111);
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned off, base, ch, o;
        logic [7:0]  b;
        logic [15:0] h;
        off  = a % 4;
        base = a - off;
        if (model_misalign(a, f3)) return 32'h0;
        if (a < DMEM_BYTES) begin
            if (f3 == 3'b000 || f3 == 3'b100) begin
                b = mdl[a];
                return (f3 == 3'b100) ? {24'h0, b} : {{24{b[7]}}, b};
            end
            if (f3 == 3'b001 || f3 == 3'b101) begin
                o = (off == 3) ? 0 : off;
                h = {mdl[base + o + 1], mdl[base + o]};
                return (f3 == 3'b101) ? {16'h0, h} : {{16{h[15]}}, h};
            end
            return {mdl[base + 3], mdl[base + 2], mdl[base + 1], mdl[base]};
        end
        if (is_mmio(a)) begin
            ch = (a - MMIO_BASE) / 4;
            return mmio_rd_data[32*ch +: 32];
        end
        return 32'h0;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [2:0] f3,
                                        input logic [31:0] v);
        int unsigned off, base;
        off  = a % 4;
        base = a - off;
        if (model_misalign(a, f3) || a >= DMEM_BYTES) return;
        if (f3 == 3'b000) begin
            mdl[a] = v[7:0];
        end else if (f3 == 3'b001) begin
            if (off != 3) begin
                mdl[a]     = v[7:0];
                mdl[a + 1] = v[15:8];
            end
        end else begin
            mdl[base]     = v[7:0];
            mdl[base + 1] = v[15:8];
            mdl[base + 2] = v[23:16];
            mdl[base + 3] = v[31:24];
        end
    endfunction

    task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sv, input logic [4:0] dst, input bit we,
                          input int stall, output logic [31:0] val,
                          output logic [4:0] dsto, output logic weo, output int lat);
        int n;
        wr_cycles = 0;
        wr_en_seen = '0;
        wr_data_seen = '0;
        @(negedge clk);
        ifc.ex_valid       = 1'b1;
        ifc.ex_is_load     = ld;
        ifc.ex_is_store    = !ld;
        ifc.ex_funct3      = f3;
        ifc.ex_addr        = a;
        ifc.ex_store_value = sv;
        ifc.ex_dstreg_num  = dst;
        ifc.ex_reg_we      = we;
        ifc.mem_ready      = (stall == 0);
        n = 0;
        while (!ifc.ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 ifc.ex_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (|mmio_wr_en) begin
                wr_cycles++;
                wr_en_seen   = mmio_wr_en;
                wr_data_seen = mmio_wr_data;
            end
            if (ifc.mem_valid) begin
                lat = c;
                break;
            end
        end
        val  = ifc.mem_load_value;
        dsto = ifc.mem_dstreg_num;
        weo  = ifc.mem_reg_we;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            ifc.mem_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.ex_valid = 1'b0; ifc.ex_is_load = 1'b0; ifc.ex_is_store = 1'b0;
        ifc.ex_funct3 = '0; ifc.ex_addr = '0; ifc.ex_store_value = '0;
        ifc.ex_dstreg_num = '0; ifc.ex_reg_we = 1'b0; ifc.mem_ready = 1'b1;
        mmio_rd_data = '0;
        #3;
        total++; if (ifc.ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ex_ready got=%b want=1", ifc.ex_ready); end
        total++; if (ifc.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b want=0", ifc.mem_valid); end
        total++; if (ifc.mem_reg_we !== 1'b0) begin bad++; $display("FAIL rst_reg_we got=%b want=0", ifc.mem_reg_we); end
        total++; if (ifc.mem_load_value !== 32'h0) begin bad++; $display("FAIL rst_load got=%h want=0", ifc.mem_load_value); end
        total++; if (ifc.mem_dstreg_num !== 5'h0) begin bad++; $display("FAIL rst_dst got=%h want=0", ifc.mem_dstreg_num); end
        total++; if (mmio_wr_en !== 4'h0) begin bad++; $display("FAIL rst_wr_en got=%b want=0", mmio_wr_en); end
        total++; if (mmio_wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data got=%h want=0", mmio_wr_data); end
`ifdef MISALIGN_TRAP_EN
        total++; if (ifc.mem_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b want=0", ifc.mem_misalign); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ifc.ex_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ex_ready got=%b want=1", ifc.ex_ready); end
        total++; if (ifc.mem_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", ifc.mem_valid); end
    endtask

    task automatic test_word();
        logic [31:0] v; logic [4:0] d; logic w; int lat;
        access(1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd3, 1'b0, 0, v, d, w, lat);
        model_store(32'h10, 3'b010, 32'hDEAD_BEEF);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_value got=%h want=0", v); end
        total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
        access(1'b1, 3'b010, 32'h10, 32'h0, 5'd9, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_value got=%h want=deadbeef", v); end
        total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", lat); end
        total++; if (d !== 5'd9) begin bad++; $display("FAIL lw_dst got=%0d want=9", d); end
        total++; if (w !== 1'b1) begin bad++; $display("FAIL lw_reg_we got=%b want=1", w); end
    endtask

    task automatic test_byte_half();
        logic [31:0] v; logic [4:0] d; logic w; int lat;
        access(1'b0, 3'b000, 32'h13, 32'h0000_0080, 5'd0, 1'b0, 0, v, d, w, lat);
        model_store(32'h13, 3'b000, 32'h80);
        access(1'b1, 3'b000, 32'h13, 32'h0, 5'd1, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb got=%h want=ffffff80", v); end
        access(1'b1, 3'b100, 32'h13, 32'h0, 5'd1, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h want=00000080", v); end
        access(1'b1, 3'b001, 32'h12, 32'h0, 5'd1, 1'b1, 0, v, d, w, lat);
        total++; if (v !== model_load(32'h12, 3'b001)) begin bad++; $display("FAIL lh got=%h want=%h", v, model_load(32'h12, 3'b001)); end
        access(1'b1, 3'b101, 32'h10, 32'h0, 5'd1, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu got=%h want=0000beef", v); end
    endtask

    task automatic test_mmio();
        logic [31:0] v; logic [4:0] d; logic w; int lat;
        mmio_rd_data = '0;
        mmio_rd_data[64 +: 32] = 32'h0000_1234;
        access(1'b1, 3'b010, MMIO_BASE + 32'd8, 32'h0, 5'd4, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'h1234) begin bad++; $display("FAIL mmio_load got=%h want=1234", v); end
        access(1'b0, 3'b010, MMIO_BASE + 32'd4, 32'h55, 5'd0, 1'b0, 0, v, d, w, lat);
        total++; if (wr_en_seen !== 4'b0010) begin bad++; $display("FAIL mmio_wr_en got=%b want=0010", wr_en_seen); end
        total++; if (wr_cycles !== 1) begin bad++; $display("FAIL mmio_wr_cycles got=%0d want=1", wr_cycles); end
        total++; if (wr_data_seen !== 32'h55) begin bad++; $display("FAIL mmio_wr_data got=%h want=55", wr_data_seen); end
    endtask

    task automatic test_stall_back_to_back();
        logic [31:0] v0;
        @(negedge clk);
        ifc.ex_valid = 1'b1; ifc.ex_is_load = 1'b1; ifc.ex_is_store = 1'b0;
        ifc.ex_funct3 = 3'b010; ifc.ex_addr = 32'h10; ifc.ex_dstreg_num = 5'd12;
        ifc.ex_reg_we = 1'b1; ifc.mem_ready = 1'b0;
        @(posedge clk);
        #1 ifc.ex_valid = 1'b0;
        repeat (2) @(negedge clk);
        v0 = ifc.mem_load_value;
        total++; if (ifc.mem_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", ifc.mem_valid); end
        total++; if (v0 !== model_load(32'h10, 3'b010)) begin bad++; $display("FAIL stall_value got=%h want=%h", v0, model_load(32'h10, 3'b010)); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ifc.mem_valid !== 1'b1 || ifc.mem_load_value !== v0 || ifc.ex_ready !== 1'b0 || ifc.mem_dstreg_num !== 5'd12) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got valid=%b val=%h rdy=%b dst=%0d want 1 %h 0 12",
                         i, ifc.mem_valid, ifc.mem_load_value, ifc.ex_ready, ifc.mem_dstreg_num, v0);
            end
        end
        ifc.ex_valid = 1'b1; ifc.ex_funct3 = 3'b100; ifc.ex_addr = 32'h13;
        ifc.ex_dstreg_num = 5'd7; ifc.mem_ready = 1'b1;
        #1;
        total++; if (ifc.ex_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", ifc.ex_ready); end
        @(posedge clk);
        #1 ifc.ex_valid = 1'b0;
        total++; if (ifc.mem_valid !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", ifc.mem_valid); end
        @(negedge clk);
        @(negedge clk);
        total++; if (ifc.mem_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", ifc.mem_valid); end
        total++; if (ifc.mem_load_value !== 32'h80) begin bad++; $display("FAIL b2b_value got=%h want=80", ifc.mem_load_value); end
        total++; if (ifc.mem_dstreg_num !== 5'd7) begin bad++; $display("FAIL b2b_dst got=%0d want=7", ifc.mem_dstreg_num); end
    endtask

    task automatic test_unmapped();
        logic [31:0] v; logic [4:0] d; logic w; int lat;
        access(1'b0, 3'b010, 32'h0, 32'h1122_3344, 5'd0, 1'b0, 0, v, d, w, lat);
        model_store(32'h0, 3'b010, 32'h1122_3344);
        access(1'b0, 3'b010, DMEM_BYTES, 32'hAAAA_5555, 5'd0, 1'b0, 0, v, d, w, lat);
        access(1'b1, 3'b010, DMEM_BYTES, 32'h0, 5'd2, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_load got=%h want=0", v); end
        access(1'b1, 3'b010, 32'h0, 32'h0, 5'd2, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'h1122_3344) begin bad++; $display("FAIL unmapped_alias got=%h want=11223344", v); end
        access(1'b1, 3'b010, DMEM_BYTES - 32'd4, 32'h0, 5'd2, 1'b1, 0, v, d, w, lat);
        access(1'b0, 3'b010, DMEM_BYTES - 32'd4, 32'h0BAD_CAFE, 5'd0, 1'b0, 0, v, d, w, lat);
        model_store(DMEM_BYTES - 32'd4, 3'b010, 32'h0BAD_CAFE);
        access(1'b1, 3'b010, DMEM_BYTES - 32'd4, 32'h0, 5'd2, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'h0BAD_CAFE) begin bad++; $display("FAIL top_word got=%h want=0badcafe", v); end
    endtask

    task automatic test_misalign();
        logic [31:0] v; logic [4:0] d; logic w; int lat;
        access(1'b1, 3'b010, 32'h11, 32'h0, 5'd6, 1'b1, 0, v, d, w, lat);
`ifdef MISALIGN_TRAP_EN
        total++; if (ifc.mem_misalign !== 1'b1) begin bad++; $display("FAIL misalign_flag got=%b want=1", ifc.mem_misalign); end
        total++; if (v !== 32'h0) begin bad++; $display("FAIL misalign_value got=%h want=0", v); end
        total++; if (w !== 1'b0) begin bad++; $display("FAIL misalign_reg_we got=%b want=0", w); end
`else
        total++; if (v !== model_load(32'h10, 3'b010)) begin bad++; $display("FAIL lw_unaligned got=%h want=%h", v, model_load(32'h10, 3'b010)); end
        total++; if (w !== 1'b1) begin bad++; $display("FAIL lw_unaligned_we got=%b want=1", w); end
`endif
    endtask

    task automatic test_reset_busy();
        logic [31:0] v; logic [4:0] d; logic w; int lat;
        access(1'b0, 3'b010, 32'h20, 32'hCAFE_F00D, 5'd0, 1'b0, 0, v, d, w, lat);
        model_store(32'h20, 3'b010, 32'hCAFE_F00D);
        @(negedge clk);
        ifc.ex_valid = 1'b1; ifc.ex_is_load = 1'b0; ifc.ex_is_store = 1'b1;
        ifc.ex_funct3 = 3'b010; ifc.ex_addr = 32'h20; ifc.ex_store_value = 32'h0BAD_BEEF;
        ifc.mem_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        ifc.ex_valid = 1'b0;
        #1;
        total++; if (ifc.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_busy_valid got=%b want=0", ifc.mem_valid); end
        total++; if (ifc.ex_ready !== 1'b1) begin bad++; $display("FAIL rst_busy_ready got=%b want=1", ifc.ex_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 3'b010, 32'h20, 32'h0, 5'd5, 1'b1, 0, v, d, w, lat);
        total++; if (v !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_busy_word got=%h want=cafef00d", v); end
    endtask

    task automatic test_random();
        logic [31:0] v, a, sv, exp_v; logic [4:0] d, dst; logic w; int lat, kind, stall;
        logic [2:0] f3; bit ld, we;
        logic [2:0] ld_codes [5];
        ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
        ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
        for (int i = 0; i < 16; i++) begin
            sv = $urandom;
            access(1'b0, 3'b010, 32'(4 * i), sv, 5'd0, 1'b0, 0, v, d, w, lat);
            model_store(32'(4 * i), 3'b010, sv);
        end
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6)      a = 32'($urandom_range(0, 63));
            else if (kind == 7) a = MMIO_BASE + 32'($urandom_range(0, 15));
            else if (kind == 8) a = 32'h8000_0000 + 32'($urandom_range(0, 255));
            else                a = DMEM_BYTES + 32'($urandom_range(0, 7));
            ld    = ($urandom_range(0, 1) == 1);
            f3    = ld ? ld_codes[$urandom_range(0, 4)] : ld_codes[$urandom_range(0, 2)];
            sv    = $urandom;
            dst   = 5'($urandom_range(0, 31));
            we    = ld;
            stall = $urandom_range(0, 2);
            mmio_rd_data = {$urandom, $urandom, $urandom, $urandom};
            exp_v = ld ? model_load(a, f3) : 32'h0;
            access(ld, f3, a, sv, dst, we, stall, v, d, w, lat);
            if (!ld) model_store(a, f3, sv);
            total++;
            if (v !== exp_v || d !== dst || w !== (we && !model_misalign(a, f3)) || lat !== 2) begin
                bad++;
                $display("FAIL rand_op%0d ld=%0d f3=%b a=%h got val=%h dst=%0d we=%b lat=%0d want %h %0d %b 2",
                         i, ld, f3, a, v, d, w, lat, exp_v, dst, we && !model_misalign(a, f3));
            end
            total++;
            if (!ld && is_mmio(a) && !model_misalign(a, f3)) begin
                if (wr_cycles !== 1 || wr_en_seen !== (4'b0001 << ((a - MMIO_BASE) / 4)) || wr_data_seen !== sv) begin
                    bad++;
                    $display("FAIL rand_mmio_wr%0d got cyc=%0d en=%b data=%h want 1 ch=%0d %h",
                             i, wr_cycles, wr_en_seen, wr_data_seen, (a - MMIO_BASE) / 4, sv);
                end
            end else if (wr_cycles !== 0) begin
                bad++;
                $display("FAIL rand_no_mmio_wr%0d got cyc=%0d want 0", i, wr_cycles);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_mmio();
        test_stall_back_to_back();
        test_unmapped();
        test_misalign();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
